// File: rtl/source_pkg.sv
// Shared types and default patterns for the
// dual-pattern serial sequence detector.
package source_pkg;

  localparam int DEF_PAT_LEN = 4;

  localparam logic [DEF_PAT_LEN-1:0] DEF_PAT_A = 4'b1011;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PAT_B = 4'b0110;

  typedef logic [DEF_PAT_LEN-1:0] win_t;

endpackage

// File: rtl/source_bit_window.sv
// Serial shift window plus saturating fill count.
// Exposes the values being loaded on this edge.
module source_bit_window
  import source_pkg::*;
#(
  parameter int N = DEF_PAT_LEN
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in,
  output logic [N-1:0] win_next,
  output logic         full_next
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);

  logic [N-1:0]  win;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_next;

  // shift in the new bit and advance the saturating fill count
  always_comb begin
    win_next  = {win[N-2:0], in};
    fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
    full_next = (fill_next == FILL_MAX);
  end

  // window and fill registers; reset wipes history
  always_ff @(posedge clock) begin
    if (reset_n) begin
      win  <= '0;
      fill <= '0;
    end else begin
      win  <= win_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/source.sv
// Bit-serial dual-pattern sequence detector.
// Flags a match of the last PAT_LEN bits.
module source
  import source_pkg::*;
#(
  parameter int                   PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PAT_A   = DEF_PAT_A,
  parameter logic [PAT_LEN-1:0]   PAT_B   = DEF_PAT_B
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  input  logic x,
  output logic out
);

  logic [PAT_LEN-1:0] win_next;
  logic               full_next;
  logic [PAT_LEN-1:0] pat;
  logic               hit;

  source_bit_window #(
    .N(PAT_LEN)
  ) u_win (
    .clock     (clock),
    .reset_n   (reset_n),
    .in        (in),
    .win_next  (win_next),
    .full_next (full_next)
  );

  // select pattern by this edge's x and compare to the new window
  always_comb begin
    pat = x ? PAT_B : PAT_A;
    hit = full_next && (win_next == pat);
  end

  // registered match flag; reset has priority
  always_ff @(posedge clock) begin
    if (reset_n) begin
      out <= 1'b0;
    end else begin
      out <= hit;
    end
  end

endmodule

// File: tb/tb_source.sv
// Self-checking bench: directed vector table
// plus randomized run against a history model.
module tb_source;

  localparam int L = 4;
  localparam logic [L-1:0] PA = 4'b1011;
  localparam logic [L-1:0] PB = 4'b0110;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic in = 1'b0;
  logic x = 1'b0;
  logic out;

  int checks = 0;
  int errors = 0;

  source dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .x       (x),
    .out     (out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst;
    logic sel;
    logic din;
    logic exp;
  } vec_t;

  vec_t vecs[$];

  // history of bits since last reset, oldest first
  logic hist[$];

  function automatic logic model_step(logic r, logic s, logic d);
    logic [L-1:0] p;
    int n;
    if (r) begin
      hist.delete();
      return 1'b0;
    end
    hist.push_back(d);
    n = hist.size();
    if (n < L) return 1'b0;
    p = s ? PB : PA;
    for (int k = 0; k < L; k++) begin
      if (hist[n - L + k] !== p[L-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic add(logic r, logic s, logic d, logic e);
    vec_t v;
    v.rst = r;
    v.sel = s;
    v.din = d;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(logic r, logic s, logic d);
    reset_n = r;
    x = s;
    in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int idx, logic e);
    checks++;
    if (out !== e) begin
      errors++;
      $display("FAIL %s[%0d]: out=%b expected=%b", name, idx, out, e);
    end
  endtask

  initial begin
    logic r, s, d, e;

    // reset held with in=1, x=1
    for (int i = 0; i < 3; i++) add(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0);
    // basic match A then break
    add(1, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 0, 1, 1);
    add(0, 0, 0, 0);
    // overlapping A
    add(1, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 0, 1, 1);
    add(0, 0, 0, 0); add(0, 0, 1, 0);
    add(0, 0, 1, 1);
    // pattern B with fill guard
    add(1, 1, 0, 0);
    add(0, 1, 1, 0); add(0, 1, 1, 0);
    add(0, 1, 0, 0);
    add(0, 1, 0, 0); add(0, 1, 1, 0);
    add(0, 1, 1, 0); add(0, 1, 0, 1);
    // x switch mid-stream
    add(1, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 1, 1, 0);
    add(0, 1, 0, 1);
    // reset mid-pattern
    add(1, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 0, 0, 0);
    add(0, 0, 1, 0);
    add(1, 0, 1, 0);
    add(0, 0, 1, 0); add(0, 0, 0, 0);
    add(0, 0, 1, 0); add(0, 0, 1, 1);

    @(negedge clock);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sel, vecs[i].din);
      check("vec", i, vecs[i].exp);
    end

    // randomized run against the history model
    hist.delete();
    drive(1, 0, 0);
    check("rand_rst", 0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 7) == 0) ? ~x : x;
      if ($urandom_range(0, 1) == 0) begin
        d = ($urandom_range(0, 1) == 1);
      end else begin
        d = s ? PB[L-1 - (hist.size() % L)]
              : PA[L-1 - (hist.size() % L)];
      end
      e = model_step(r, s, d);
      drive(r, s, d);
      check("rand", i, e);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
